// File: rtl/rf_pkg.sv
// Shared types and default sizes for the multi-port register file.
package rf_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at writeback.
// Read-side pending flags are suppressed when the matching write is bypassed this cycle.
module rf_scoreboard #(
    parameter  int NREGS = 32,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_set_en,
    input  logic [AW-1:0]     i_set_addr,
    input  logic              i_clr_en,
    input  logic [AW-1:0]     i_clr_addr,
    input  logic [NRD*AW-1:0] i_rd_addr,
    output logic [NRD-1:0]    o_pending
);

    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_nxt;

    // Next scoreboard contents: clear first so a same-address set wins; x0 never pends.
    always_comb begin
        w_pend_nxt = r_pend;
        if (i_clr_en) begin
            w_pend_nxt[i_clr_addr] = 1'b0;
        end
        if (i_set_en) begin
            w_pend_nxt[i_set_addr] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
        if (i_flush) begin
            w_pend_nxt = '0;
        end
    end

    // Scoreboard register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    // Per-port pending lookup with bypass suppression.
    always_comb begin
        o_pending = '0;
        for (int i = 0; i < NRD; i++) begin
            o_pending[i] = r_pend[i_rd_addr[i*AW +: AW]]
                         && !(i_clr_en && (i_clr_addr == i_rd_addr[i*AW +: AW]))
                         && !i_flush;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port integer register file with write-first bypass, x0 hardwired
// to zero, a sequential clear engine and a pending-write scoreboard.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | normal operation: reads, writes and scoreboard updates honoured
// CLEAR | zeroing register[cnt] each cycle; outputs forced to 0, core stalls
module regfile_mp_sb
    import rf_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NRD*AW-1:0]   i_rd_addr,
    output logic [NRD*XLEN-1:0] o_rd_data,
    output logic [NRD-1:0]      o_rd_pending,
    input  logic                i_we,
    input  logic [AW-1:0]       i_wa,
    input  logic [XLEN-1:0]     i_wd,
    input  logic                i_sb_set,
    input  logic [AW-1:0]       i_sb_addr,
    input  logic                i_clr_req,
    output logic                o_clr_busy
);

    logic [XLEN-1:0] r_mem [NREGS];
    rf_state_e       r_state;
    rf_state_e       w_state_nxt;
    logic [AW-1:0]   r_clr_cnt;
    logic            w_clearing;
    logic            w_wr_en;
    logic            w_cnt_last;
    logic [AW-1:0]   w_ra;

    // Counter exits at NREGS-1 so it never wraps back to x0.
    assign w_cnt_last = (r_clr_cnt == AW'(NREGS - 1));

    // State register; reset always starts a fresh clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clr_req is only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (i_clr_req)  w_state_nxt = CLEAR;
            CLEAR: if (w_cnt_last) w_state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs and write qualification.
    always_comb begin
        w_clearing = (r_state == CLEAR);
        w_wr_en    = !w_clearing && i_we && (i_wa != '0);
    end

    assign o_clr_busy = w_clearing;

    // Clear counter: loads 1 on entry, steps through to NREGS-1 and holds there.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clr_cnt <= AW'(1);
        end else if (r_state == IDLE) begin
            if (i_clr_req) begin
                r_clr_cnt <= AW'(1);
            end
        end else if (!w_cnt_last) begin
            r_clr_cnt <= r_clr_cnt + AW'(1);
        end
    end

    // Storage array, no reset: zeroed by the clear engine, otherwise the write port.
    always_ff @(posedge i_clk) begin
        if (w_clearing) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_en) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    // Read muxes with x0 forcing and write-first bypass.
    always_comb begin
        o_rd_data = '0;
        w_ra      = '0;
        for (int i = 0; i < NRD; i++) begin
            w_ra = i_rd_addr[i*AW +: AW];
            if (!w_clearing && (w_ra != '0)) begin
                if (i_we && (i_wa == w_ra)) begin
                    o_rd_data[i*XLEN +: XLEN] = i_wd;
                end else begin
                    o_rd_data[i*XLEN +: XLEN] = r_mem[w_ra];
                end
            end
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD)
    ) u_scoreboard (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_flush    (w_clearing),
        .i_set_en   (i_sb_set),
        .i_set_addr (i_sb_addr),
        .i_clr_en   (i_we),
        .i_clr_addr (i_wa),
        .i_rd_addr  (i_rd_addr),
        .o_pending  (o_rd_pending)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: the driver pushes the expected outputs of
// each cycle into a queue, a monitor pops and compares them mid-cycle.
module tb_regfile_mp_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                i_clk = 1'b0;
    logic                i_rst_n;
    logic [NRD*AW-1:0]   i_rd_addr;
    logic [NRD*XLEN-1:0] o_rd_data;
    logic [NRD-1:0]      o_rd_pending;
    logic                i_we;
    logic [AW-1:0]       i_wa;
    logic [XLEN-1:0]     i_wd;
    logic                i_sb_set;
    logic [AW-1:0]       i_sb_addr;
    logic                i_clr_req;
    logic                o_clr_busy;

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_rd_addr    (i_rd_addr),
        .o_rd_data    (o_rd_data),
        .o_rd_pending (o_rd_pending),
        .i_we         (i_we),
        .i_wa         (i_wa),
        .i_wd         (i_wd),
        .i_sb_set     (i_sb_set),
        .i_sb_addr    (i_sb_addr),
        .i_clr_req    (i_clr_req),
        .o_clr_busy   (o_clr_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string           name;
        logic [XLEN-1:0] d0;
        logic [XLEN-1:0] d1;
        logic [1:0]      pend;
        logic            busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Monitor: compare everything queued for this cycle at the falling edge.
    always @(negedge i_clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({o_rd_data, o_rd_pending, o_clr_busy} !== {e.d1, e.d0, e.pend, e.busy}) begin
                n_errors++;
                $display("FAIL %s: got d1=%h d0=%h pend=%b busy=%b, want d1=%h d0=%h pend=%b busy=%b",
                         e.name, o_rd_data[2*XLEN-1:XLEN], o_rd_data[XLEN-1:0], o_rd_pending,
                         o_clr_busy, e.d1, e.d0, e.pend, e.busy);
            end
        end
    end

    function automatic logic [NRD*AW-1:0] ra(input int p1, input int p0);
        return {AW'(p1), AW'(p0)};
    endfunction

    task automatic quiet();
        i_we      = 1'b0;
        i_wa      = '0;
        i_wd      = '0;
        i_sb_set  = 1'b0;
        i_sb_addr = '0;
        i_clr_req = 1'b0;
    endtask

    // Queue the expectation for the current cycle, then advance one cycle.
    task automatic step(input string nm, input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1,
                        input logic [1:0] pend, input logic busy);
        exp_t e;
        e.name = nm; e.d0 = d0; e.d1 = d1; e.pend = pend; e.busy = busy;
        exp_q.push_back(e);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, bench did not complete");
        $fatal(1);
    end

    initial begin
        i_rst_n   = 1'b0;
        i_rd_addr = ra(5, 3);
        quiet();
        repeat (2) @(posedge i_clk);
        #1;
        step("in_reset", 0, 0, 2'b00, 1'b1);
        i_rst_n = 1'b1;

        // Clear after reset lasts exactly NREGS-1 cycles.
        for (int i = 1; i <= NREGS - 1; i++) step($sformatf("reset_clear_c%0d", i), 0, 0, 2'b00, 1'b1);
        step("reset_clear_done", 0, 0, 2'b00, 1'b0);
        for (int a = 0; a < NREGS; a++) begin
            i_rd_addr = ra(NREGS - 1 - a, a);
            step($sformatf("zero_after_reset_a%0d", a), 0, 0, 2'b00, 1'b0);
        end

        // Write with same-cycle bypass, then persistent read.
        i_we = 1'b1; i_wa = 5; i_wd = 32'hDEADBEEF; i_rd_addr = ra(0, 5);
        step("bypass_x5", 32'hDEADBEEF, 0, 2'b00, 1'b0);
        quiet();
        step("read_x5_c1", 32'hDEADBEEF, 0, 2'b00, 1'b0);
        step("read_x5_c2", 32'hDEADBEEF, 0, 2'b00, 1'b0);

        // x0 ignores writes and scoreboard sets.
        i_we = 1'b1; i_wa = 0; i_wd = 32'hFFFFFFFF; i_rd_addr = ra(0, 0);
        step("x0_write_cycle", 0, 0, 2'b00, 1'b0);
        quiet();
        step("x0_after_write", 0, 0, 2'b00, 1'b0);
        i_sb_set = 1'b1; i_sb_addr = 0;
        step("x0_sb_set_cycle", 0, 0, 2'b00, 1'b0);
        quiet();
        step("x0_sb_after", 0, 0, 2'b00, 1'b0);

        // Scoreboard set then cleared by writeback.
        i_sb_set = 1'b1; i_sb_addr = 7; i_rd_addr = ra(7, 5);
        step("sb7_set_cycle", 32'hDEADBEEF, 0, 2'b00, 1'b0);
        quiet();
        step("sb7_pending_c1", 32'hDEADBEEF, 0, 2'b10, 1'b0);
        step("sb7_pending_c2", 32'hDEADBEEF, 0, 2'b10, 1'b0);
        i_we = 1'b1; i_wa = 7; i_wd = 32'h12;
        step("sb7_write_cycle", 32'hDEADBEEF, 32'h12, 2'b00, 1'b0);
        quiet();
        step("sb7_after_write", 32'hDEADBEEF, 32'h12, 2'b00, 1'b0);

        // Same-address set and write: set wins, data written; aliased ports.
        i_sb_set = 1'b1; i_sb_addr = 9; i_we = 1'b1; i_wa = 9; i_wd = 32'h34; i_rd_addr = ra(9, 9);
        step("sb9_setwr_cycle", 32'h34, 32'h34, 2'b00, 1'b0);
        quiet();
        step("sb9_set_wins", 32'h34, 32'h34, 2'b11, 1'b0);

        // Set and clear on different addresses both apply.
        i_sb_set = 1'b1; i_sb_addr = 11; i_we = 1'b1; i_wa = 9; i_wd = 32'h35; i_rd_addr = ra(11, 9);
        step("diff_setclr_cycle", 32'h35, 0, 2'b00, 1'b0);
        quiet();
        step("diff_setclr_after", 32'h35, 0, 2'b10, 1'b0);

        // Requested clear, interrupted by reset at clear cycle 10.
        i_we = 1'b1; i_wa = 3; i_wd = 32'h55; i_rd_addr = ra(3, 3);
        step("x3_write", 32'h55, 32'h55, 2'b00, 1'b0);
        quiet();
        i_clr_req = 1'b1; i_rd_addr = ra(11, 3);
        step("clr_req_cycle", 32'h55, 0, 2'b10, 1'b0);
        quiet();
        for (int i = 1; i <= 9; i++) step($sformatf("req_clear_c%0d", i), 0, 0, 2'b00, 1'b1);
        i_rst_n = 1'b0;
        step("reset_mid_clear", 0, 0, 2'b00, 1'b1);
        i_rst_n = 1'b1;
        for (int i = 1; i <= NREGS - 1; i++) begin
            if (i == 20) begin
                i_we = 1'b1; i_wa = 2; i_wd = 32'hAAAA; i_sb_set = 1'b1; i_sb_addr = 2;
            end else if (i == 25) begin
                i_clr_req = 1'b1;
            end else begin
                quiet();
            end
            step($sformatf("restart_clear_c%0d", i), 0, 0, 2'b00, 1'b1);
        end
        quiet();
        i_rd_addr = ra(2, 3);
        step("restart_clear_done", 0, 0, 2'b00, 1'b0);
        i_rd_addr = ra(11, 9);
        step("cleared_x9_x11", 0, 0, 2'b00, 1'b0);

        @(negedge i_clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
